// File: rtl/tx_arbiter_if.sv
// rtl/tx_arbiter_if.sv - request, TX engine and reply-routing signals of the TX arbiter
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 8
`endif

interface tx_arbiter_if #(
    parameter int CMD_BITS = `TX_CMD_BITS,
    parameter int NSHIFT   = 2
);
    // prefetcher requester
    logic                pf_cmd_valid;
    logic [CMD_BITS-1:0] pf_cmd;
    logic                pf_reply_wanted;
    logic [NSHIFT-1:0]   pf_data;
    logic                pf_started;
    logic                pf_data_next;

    // scheduler requester
    logic                sc_cmd_valid;
    logic [CMD_BITS-1:0] sc_cmd;
    logic                sc_reply_wanted;
    logic [NSHIFT-1:0]   sc_data;
    logic                sc_started;
    logic                sc_data_next;

    // grant fences
    logic                reserve_tx;
    logic                block_prefetch;

    // TX engine side
    logic                tx_command_valid;
    logic [CMD_BITS-1:0] tx_command;
    logic                tx_reply_wanted;
    logic [NSHIFT-1:0]   tx_data;
    logic                tx_command_started;
    logic                tx_data_next;
    logic                tx_done;

    // RX reply routing
    logic                rx_done;
    logic                rx_owner_valid;
    logic                rx_owner;
    logic                protocol_error;

    // arbiter view
    modport slave (
        input  pf_cmd_valid, pf_cmd, pf_reply_wanted, pf_data,
        output pf_started, pf_data_next,
        input  sc_cmd_valid, sc_cmd, sc_reply_wanted, sc_data,
        output sc_started, sc_data_next,
        input  reserve_tx, block_prefetch,
        output tx_command_valid, tx_command, tx_reply_wanted, tx_data,
        input  tx_command_started, tx_data_next, tx_done,
        input  rx_done,
        output rx_owner_valid, rx_owner, protocol_error
    );

    // requesters / TX engine / RX view
    modport master (
        output pf_cmd_valid, pf_cmd, pf_reply_wanted, pf_data,
        input  pf_started, pf_data_next,
        output sc_cmd_valid, sc_cmd, sc_reply_wanted, sc_data,
        input  sc_started, sc_data_next,
        output reserve_tx, block_prefetch,
        input  tx_command_valid, tx_command, tx_reply_wanted, tx_data,
        output tx_command_started, tx_data_next, tx_done,
        output rx_done,
        input  rx_owner_valid, rx_owner, protocol_error
    );
endinterface

// File: rtl/tx_arbiter.sv
// rtl/tx_arbiter.sv - shares the serial TX channel between prefetcher and scheduler and tracks reply owners
`ifndef TX_CMD_BITS
`define TX_CMD_BITS 8
`endif

module tx_arbiter #(
    parameter int CMD_BITS    = `TX_CMD_BITS,
    parameter int NSHIFT      = 2,
    parameter int REPLY_DEPTH = 2   // power of two, at least 2
) (
    input  logic          clk,
    input  logic          reset_n,
    tx_arbiter_if.slave   bus
);

    localparam int PTR_W = $clog2(REPLY_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(REPLY_DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_OWN_PF = 2'd1;
    localparam logic [1:0] ST_OWN_SC = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [REPLY_DEPTH-1:0] owner_q, owner_d;
    logic                   err_q, err_d;

    logic                   in_idle;
    logic                   sc_req;
    logic                   pf_req;
    logic                   win_reply;
    logic                   fifo_blocked;
    logic                   sc_win;
    logic                   pf_win;
    logic                   cmd_valid;
    logic                   accept;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;

    // Arbitration in IDLE: scheduler first, prefetch only when nothing fences it.
    // A pop in the same cycle frees a slot, so a full FIFO does not block a grant while rx_done is high.
    always_comb begin
        in_idle      = (state_q == ST_IDLE);
        sc_req       = in_idle && bus.sc_cmd_valid;
        pf_req       = in_idle && !bus.sc_cmd_valid && bus.pf_cmd_valid
                       && !bus.reserve_tx && !bus.block_prefetch;
        win_reply    = sc_req ? bus.sc_reply_wanted : (pf_req && bus.pf_reply_wanted);
        fifo_blocked = win_reply && (count_q == DEPTH_CNT) && !bus.rx_done;
        sc_win       = sc_req && !fifo_blocked;
        pf_win       = pf_req && !fifo_blocked;
        cmd_valid    = sc_win || pf_win;
        accept       = cmd_valid && bus.tx_command_started;
    end

    // Command offer and acceptance strobes towards the TX engine and requesters.
    always_comb begin
        bus.tx_command_valid = cmd_valid;
        bus.tx_reply_wanted  = cmd_valid && win_reply;
        bus.tx_command       = '0;
        if (sc_win) begin
            bus.tx_command = bus.sc_cmd;
        end else if (pf_win) begin
            bus.tx_command = bus.pf_cmd;
        end
        bus.sc_started = sc_win && bus.tx_command_started;
        bus.pf_started = pf_win && bus.tx_command_started;
    end

    // Payload routing follows the registered owner; IDLE drives nothing.
    always_comb begin
        bus.tx_data      = '0;
        bus.pf_data_next = 1'b0;
        bus.sc_data_next = 1'b0;
        if (state_q == ST_OWN_PF) begin
            bus.tx_data      = bus.pf_data;
            bus.pf_data_next = bus.tx_data_next;
        end else if (state_q == ST_OWN_SC) begin
            bus.tx_data      = bus.sc_data;
            bus.sc_data_next = bus.tx_data_next;
        end
    end

    // Reply-owner FIFO: in-order record of who expects each outstanding reply.
    always_comb begin
        fifo_empty = (count_q == '0);
        push       = accept && win_reply;
        pop        = bus.rx_done && !fifo_empty;
        owner_d    = owner_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            owner_d[wr_ptr_q] = sc_win;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        bus.rx_owner_valid = !fifo_empty;
        bus.rx_owner       = fifo_empty ? 1'b0 : owner_q[rd_ptr_q];
    end

    // Ownership state: acceptance claims TX, tx_done hands it back.
    always_comb begin
        state_d = state_q;
        if (in_idle) begin
            if (accept) begin
                state_d = sc_win ? ST_OWN_SC : ST_OWN_PF;
            end
        end else if (bus.tx_done) begin
            state_d = ST_IDLE;
        end
    end

    // Sticky protocol error: unoffered accept, done while idle, or pop of an empty FIFO.
    always_comb begin
        err_d = err_q;
        if (bus.tx_command_started && !cmd_valid) begin
            err_d = 1'b1;
        end
        if (bus.tx_done && in_idle) begin
            err_d = 1'b1;
        end
        if (bus.rx_done && fifo_empty) begin
            err_d = 1'b1;
        end
        bus.protocol_error = err_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            owner_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            owner_q  <= owner_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb/tb_tx_arbiter.sv - self-checking bench for tx_arbiter with a queue-based reference model
module tb_tx_arbiter;

    localparam int CMD_BITS    = 8;
    localparam int NSHIFT      = 2;
    localparam int REPLY_DEPTH = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    tx_arbiter_if #(.CMD_BITS(CMD_BITS), .NSHIFT(NSHIFT)) bus ();

    tx_arbiter #(.CMD_BITS(CMD_BITS), .NSHIFT(NSHIFT), .REPLY_DEPTH(REPLY_DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: owner -1 idle, 0 prefetch, 1 scheduler; queue of reply owners
    int m_owner = -1;
    bit m_q[$];
    bit m_err = 1'b0;

    // expectations for the current cycle
    bit                e_sc_w, e_pf_w, e_valid, e_rw;
    logic [CMD_BITS-1:0] e_cmd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void eval_model();
        bit idle, want, full;
        idle   = (m_owner == -1);
        e_sc_w = idle && bus.sc_cmd_valid;
        e_pf_w = idle && !bus.sc_cmd_valid && bus.pf_cmd_valid && !bus.reserve_tx && !bus.block_prefetch;
        want   = e_sc_w ? bus.sc_reply_wanted : (e_pf_w ? bus.pf_reply_wanted : 1'b0);
        full   = (m_q.size() == REPLY_DEPTH) && !bus.rx_done;
        if (want && full) begin
            e_sc_w = 1'b0;
            e_pf_w = 1'b0;
        end
        e_valid = e_sc_w || e_pf_w;
        e_rw    = e_valid && want;
        e_cmd   = e_sc_w ? bus.sc_cmd : (e_pf_w ? bus.pf_cmd : '0);
    endfunction

    task automatic settle();
        logic [NSHIFT-1:0] e_data;
        #1;
        eval_model();
        e_data = (m_owner == 0) ? bus.pf_data : ((m_owner == 1) ? bus.sc_data : '0);
        chk("tx_command_valid", bus.tx_command_valid, e_valid);
        chk("tx_command", bus.tx_command, e_cmd);
        chk("tx_reply_wanted", bus.tx_reply_wanted, e_rw);
        chk("pf_started", bus.pf_started, e_pf_w && bus.tx_command_started);
        chk("sc_started", bus.sc_started, e_sc_w && bus.tx_command_started);
        chk("tx_data", bus.tx_data, e_data);
        chk("pf_data_next", bus.pf_data_next, (m_owner == 0) && bus.tx_data_next);
        chk("sc_data_next", bus.sc_data_next, (m_owner == 1) && bus.tx_data_next);
        chk("rx_owner_valid", bus.rx_owner_valid, m_q.size() != 0);
        chk("rx_owner", bus.rx_owner, (m_q.size() != 0) ? m_q[0] : 1'b0);
        chk("protocol_error", bus.protocol_error, m_err);
    endtask

    task automatic advance();
        if (!reset_n) begin
            m_owner = -1;
            m_q.delete();
            m_err = 1'b0;
        end else begin
            if (bus.tx_command_started && !e_valid) m_err = 1'b1;
            if (bus.tx_done && m_owner == -1) m_err = 1'b1;
            if (bus.rx_done) begin
                if (m_q.size() == 0) m_err = 1'b1;
                else void'(m_q.pop_front());
            end
            if (e_valid && bus.tx_command_started) begin
                if (e_rw) m_q.push_back(e_sc_w);
                m_owner = e_sc_w ? 1 : 0;
            end else if (m_owner != -1 && bus.tx_done) begin
                m_owner = -1;
            end
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.pf_cmd_valid = 0; bus.pf_cmd = '0; bus.pf_reply_wanted = 0; bus.pf_data = '0;
        bus.sc_cmd_valid = 0; bus.sc_cmd = '0; bus.sc_reply_wanted = 0; bus.sc_data = '0;
        bus.reserve_tx = 0; bus.block_prefetch = 0;
        bus.tx_command_started = 0; bus.tx_data_next = 0; bus.tx_done = 0; bus.rx_done = 0;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        @(negedge clk);
        settle(); advance();
        settle(); advance();
        reset_n = 1'b1;

        // reset state
        settle();
        chk("rst_valid", bus.tx_command_valid, 0);
        chk("rst_rov", bus.rx_owner_valid, 0);
        chk("rst_err", bus.protocol_error, 0);
        advance();

        // priority: scheduler beats prefetcher
        bus.pf_cmd_valid = 1; bus.pf_cmd = 8'h3C;
        bus.sc_cmd_valid = 1; bus.sc_cmd = 8'hA5; bus.sc_reply_wanted = 1;
        bus.tx_command_started = 1;
        settle();
        chk("prio_cmd", bus.tx_command, 8'hA5);
        chk("prio_sc_started", bus.sc_started, 1);
        chk("prio_pf_started", bus.pf_started, 0);
        advance();
        clear_inputs();
        bus.sc_data = 2'b01; bus.tx_data_next = 1;
        settle();
        chk("own_sc_valid", bus.tx_command_valid, 0);
        chk("own_sc_data", bus.tx_data, 2'b01);
        chk("own_sc_dn", bus.sc_data_next, 1);
        bus.tx_done = 1;
        advance();
        clear_inputs();

        // reservation fences prefetch
        bus.reserve_tx = 1; bus.pf_cmd_valid = 1; bus.pf_cmd = 8'h5A; bus.pf_reply_wanted = 1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("resv_valid", bus.tx_command_valid, 0);
            advance();
        end
        bus.reserve_tx = 0;
        settle();
        chk("resv_drop_valid", bus.tx_command_valid, 1);
        chk("resv_drop_cmd", bus.tx_command, 8'h5A);
        bus.tx_command_started = 1;
        settle();
        advance();
        clear_inputs();

        // payload routing: 8 beats, done on the 8th, no grant in the done cycle
        bus.pf_data = 2'b10; bus.tx_data_next = 1;
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                bus.tx_done = 1; bus.sc_cmd_valid = 1; bus.sc_cmd = 8'h11;
            end
            settle();
            chk("pay_data", bus.tx_data, 2'b10);
            chk("pay_pf_dn", bus.pf_data_next, 1);
            chk("pay_sc_dn", bus.sc_data_next, 0);
            if (i == 7) chk("pay_done_no_grant", bus.tx_command_valid, 0);
            advance();
        end
        bus.tx_done = 0; bus.tx_data_next = 0;
        settle();
        chk("pay_idle_grant", bus.tx_command_valid, 1);
        chk("pay_idle_data", bus.tx_data, 0);
        advance();

        // reply ordering: FIFO full [sc, pf] blocks a third reply-wanting request
        bus.sc_reply_wanted = 1; bus.sc_cmd = 8'h22;
        settle();
        chk("ord_blocked", bus.tx_command_valid, 0);
        chk("ord_head_sc", bus.rx_owner, 1);
        advance();
        bus.rx_done = 1;
        settle();
        chk("ord_pop_frees", bus.tx_command_valid, 1);
        advance();
        bus.rx_done = 0;
        settle();
        chk("ord_head_pf", bus.rx_owner, 0);
        chk("ord_granted", bus.tx_command_valid, 1);
        bus.tx_command_started = 1;
        settle();
        advance();
        clear_inputs();
        bus.tx_done = 1;
        settle();
        advance();
        clear_inputs();

        // boundary: push and pop together on a full FIFO [pf, sc]
        bus.pf_cmd_valid = 1; bus.pf_reply_wanted = 1; bus.pf_cmd = 8'h77;
        bus.rx_done = 1; bus.tx_command_started = 1;
        settle();
        chk("bnd_valid", bus.tx_command_valid, 1);
        chk("bnd_pf_started", bus.pf_started, 1);
        chk("bnd_head", bus.rx_owner, 0);
        advance();
        clear_inputs();
        settle();
        chk("bnd_new_head", bus.rx_owner, 1);
        chk("bnd_nonempty", bus.rx_owner_valid, 1);
        chk("bnd_no_err", bus.protocol_error, 0);
        bus.tx_done = 1;
        advance();
        clear_inputs();
        bus.rx_done = 1;
        settle();
        chk("bnd_pop1", bus.rx_owner, 1);
        advance();
        settle();
        chk("bnd_pop2", bus.rx_owner, 0);
        advance();
        bus.rx_done = 0;
        settle();
        chk("bnd_empty", bus.rx_owner_valid, 0);
        advance();

        // errors: pop of empty FIFO is sticky
        bus.rx_done = 1;
        settle();
        advance();
        bus.rx_done = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("err_sticky", bus.protocol_error, 1);
            advance();
        end

        // reset mid OWN_SC
        bus.sc_cmd_valid = 1; bus.sc_reply_wanted = 1; bus.sc_cmd = 8'h99; bus.tx_command_started = 1;
        settle();
        advance();
        clear_inputs();
        bus.sc_data = 2'b11; bus.tx_data_next = 1;
        settle();
        chk("rst_mid_dn", bus.sc_data_next, 1);
        advance();
        reset_n = 1'b0;
        settle();
        advance();
        reset_n = 1'b1;
        settle();
        chk("rst_after_dn", bus.sc_data_next, 0);
        chk("rst_after_data", bus.tx_data, 0);
        chk("rst_after_err", bus.protocol_error, 0);
        chk("rst_after_rov", bus.rx_owner_valid, 0);
        advance();
        clear_inputs();

        // randomized traffic
        for (int i = 0; i < 4000; i++) begin
            reset_n              = ($urandom_range(0, 299) != 0);
            bus.pf_cmd_valid     = $urandom_range(0, 1);
            bus.pf_cmd           = CMD_BITS'($urandom);
            bus.pf_reply_wanted  = $urandom_range(0, 1);
            bus.pf_data          = NSHIFT'($urandom);
            bus.sc_cmd_valid     = ($urandom_range(0, 2) == 0);
            bus.sc_cmd           = CMD_BITS'($urandom);
            bus.sc_reply_wanted  = $urandom_range(0, 1);
            bus.sc_data          = NSHIFT'($urandom);
            bus.reserve_tx       = ($urandom_range(0, 3) == 0);
            bus.block_prefetch   = ($urandom_range(0, 3) == 0);
            bus.tx_data_next     = $urandom_range(0, 1);
            bus.tx_done          = (m_owner != -1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 99) == 0);
            bus.rx_done          = (m_q.size() != 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 99) == 0);
            bus.tx_command_started = 0;
            eval_model();
            bus.tx_command_started = e_valid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 99) == 0);
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tx_arbiter.md
# tx_arbiter

Shares the single serial TX channel between the instruction prefetcher and the decoder/scheduler, and tracks which of them owns each outstanding reply so that RX data is routed to the correct consumer. Sits between the two TX requesters and the TX engine. The scheduler has strict priority, and its `reserve_tx` request fences off new prefetch commands. A small in-order FIFO records the owner of each command that expects a reply.

## Interface
Parameters:
- CMD_BITS, default `TX_CMD_BITS`: width of a TX command.
- NSHIFT, default 2: bits per TX/RX data beat.
- REPLY_DEPTH, default 2: maximum outstanding replies; must be a power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous reset, active low.
- pf_cmd_valid  in  1  prefetcher requests a TX command.
- pf_cmd  in  CMD_BITS  prefetcher command.
- pf_reply_wanted  in  1  prefetcher command expects a reply.
- pf_data  in  NSHIFT  prefetcher payload beat.
- pf_started  out  1  prefetcher command accepted this cycle.
- pf_data_next  out  1  prefetcher must advance its payload.
- sc_cmd_valid  in  1  scheduler command request.
- sc_cmd  in  CMD_BITS  scheduler command.
- sc_reply_wanted  in  1  scheduler command expects a reply.
- sc_data  in  NSHIFT  scheduler payload beat.
- sc_started  out  1  scheduler command accepted this cycle.
- sc_data_next  out  1  scheduler must advance its payload.
- reserve_tx  in  1  scheduler will need TX soon; blocks prefetch grants.
- block_prefetch  in  1  blocks prefetch grants.
- tx_command_valid  out  1  command offered to the TX engine.
- tx_command  out  CMD_BITS  offered command.
- tx_reply_wanted  out  1  offered command expects a reply.
- tx_data  out  NSHIFT  payload beat of the current owner.
- tx_command_started  in  1  TX engine accepts the offered command.
- tx_data_next  in  1  TX engine consumed a beat.
- tx_done  in  1  last beat of the current transaction sent.
- rx_done  in  1  a reply has been fully received.
- rx_owner_valid  out  1  reply FIFO not empty.
- rx_owner  out  1  owner of the oldest outstanding reply: 0 = prefetch, 1 = scheduler.
- protocol_error  out  1  sticky error flag.

## Operation
- The state machine has three states:
  - IDLE: no transaction in progress.
  - OWN_PF: the prefetcher owns TX.
  - OWN_SC: the scheduler owns TX.
- In IDLE, the winner is chosen combinationally:
  - The scheduler wins if sc_cmd_valid is high.
  - Otherwise the prefetcher wins if pf_cmd_valid is high and reserve_tx, block_prefetch and the scheduler's request are all low.
- FIFO-full gate: if the winner's reply_wanted is high and the reply FIFO is full, there is no winner.
- tx_command_valid is high only in IDLE with a winner. tx_command and tx_reply_wanted are muxed from the winner; both are 0 when there is no winner.
- tx_command_started while tx_command_valid is high:
  - Pulses the winner's `*_started` in the same cycle.
  - Moves the state to OWN_PF or OWN_SC.
  - Pushes the owner bit into the reply FIFO if tx_reply_wanted is high.
- tx_command_started while tx_command_valid is low is ignored and sets protocol_error.
- In OWN_x:
  - tx_data = x_data.
  - x_data_next = tx_data_next; the other requester's data_next is 0.
  - tx_done returns the state to IDLE.
- tx_done in IDLE is ignored and sets protocol_error.
- In IDLE, tx_data = 0 and both data_next outputs are 0.
- Reply FIFO:
  - rx_done pops the head.
  - rx_owner is the head entry; it is 0 when the FIFO is empty.
  - Push and pop in the same cycle leave the count unchanged, including when the FIFO is full.
  - Pop when empty is ignored and sets protocol_error.
  - Read and write pointers wrap modulo REPLY_DEPTH.
- protocol_error clears only on reset.

## Timing
- Reset (reset_n low at a clk edge) forces:
  - state = IDLE, FIFO empty, pointers 0, protocol_error 0.
  - All outputs 0 afterwards, except combinational outputs that depend on the request inputs.
- Reset takes effect mid-transaction too. An in-flight transaction and its pending replies are discarded, and no started or data_next pulses follow.
- Grant latency is 0 cycles: tx_command_valid follows the request inputs combinationally in IDLE.
- Acceptance takes effect at the accepting edge. The owner state is visible in the next cycle.
- A tx_done cycle forces at least one IDLE cycle before the next grant. No back-to-back grant happens in the done cycle.
- tx_done and tx_data_next in the same cycle: data_next is still routed to the owner in that cycle.
- tx_command_started together with rx_done on a full FIFO: the push succeeds because the pop happens in the same cycle.
- Requests may change in any cycle while IDLE. No request is latched until acceptance.

## Test plan
- Priority: pf_cmd_valid=1 and sc_cmd_valid=1 in IDLE, then tx_command_started=1 → tx_command=sc_cmd, sc_started=1, pf_started=0; next cycle state OWN_SC.
- Reservation: reserve_tx=1, pf_cmd_valid=1, sc_cmd_valid=0 for 5 cycles → tx_command_valid=0 throughout; drop reserve_tx → valid=1 with pf_cmd in the same cycle.
- Payload routing: prefetcher owns TX, pf_data=2'b10, tx_data_next pulses 8 times, tx_done on the 8th → tx_data=2'b10, 8 pf_data_next pulses, 0 sc_data_next; IDLE on the next cycle, with no grant in the done cycle.
- Reply ordering: accept SC with reply, then PF with reply (REPLY_DEPTH=2), then a third request with reply → no valid for the third; rx_owner=1, rx_done → rx_owner=0, third request is now granted.
- Boundary: with the FIFO full, tx_command_started (reply wanted) and rx_done in the same cycle → count stays 2, order preserved.
- Errors and reset: rx_done with the FIFO empty → protocol_error=1 and stays high; reset_n=0 mid OWN_SC → IDLE, FIFO empty, protocol_error=0, no further sc_data_next.
